usb_frame_scheduler: RTL

- Sequences the USB host transaction engine. Keeps the 1 ms frame timer and issues an SOF request to the SOF transmitter at each frame boundary.
- Accepts one software transaction request at a time and hands it to the host transaction controller over the transReq/transType/transDone/clearTXReq handshake.
- Stops new transactions from starting inside a guard band before the next SOF.

---
 rtl/usb_frame_scheduler.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/usb_frame_scheduler.sv
// usb_frame_scheduler: 1 ms frame timer, SOF issue and single-transaction
// sequencing towards the host transaction controller. A guard band before
// each frame boundary stops new transactions from being launched.
module usb_frame_scheduler #(
    parameter int FRAME_PERIOD = 48000,
    parameter int GUARD_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sofEnable,
    input  logic        swTransReq,
    input  logic [1:0]  swTransType,
    output logic        swTransBusy,
    output logic        swTransDone,
    output logic        transReq,
    output logic [1:0]  transType,
    input  logic        transDone,
    input  logic        clearTXReq,
    output logic        sofTxReq,
    input  logic        sofTxDone,
    output logic [10:0] frameNum,
    output logic        sofSent,
    output logic [15:0] frameTimer
);

    typedef enum logic [1:0] {
        IDLE,
        SOF_TX,
        TRANS_ACT,
        TRANS_WAIT
    } state_e;

    localparam logic [15:0] LAST_TICK    = 16'(FRAME_PERIOD - 1);
    localparam logic [15:0] LAUNCH_LIMIT = 16'(FRAME_PERIOD - GUARD_CYCLES);
    localparam logic [3:0]  WAIT_LAST    = 4'd15;

    state_e      state;
    state_e      nextState;
    logic        sofDue;
    logic [1:0]  latchedType;
    logic [3:0]  waitCnt;
    logic        frameWrap;
    logic        launchOk;
    logic        transComplete;
    logic        swCapture;
    logic        sofStart;
    logic        transStart;

    assign frameWrap     = sofEnable && (frameTimer == LAST_TICK);
    assign launchOk      = !sofEnable || (frameTimer < LAUNCH_LIMIT);
    // Either completion strobe from the host controller ends the transaction.
    assign transComplete = clearTXReq || transDone;
    // A request coinciding with the done pulse is dropped, not queued.
    assign swCapture     = swTransReq && !swTransBusy && !swTransDone;
    assign sofStart      = (state == IDLE) && (nextState == SOF_TX);
    assign transStart    = (state == IDLE) && (nextState == TRANS_ACT);

    // Frame timer and sticky SOF-due flag.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            frameTimer <= '0;
            sofDue     <= 1'b0;
        end else if (!sofEnable) begin
            frameTimer <= '0;
            sofDue     <= 1'b0;
        end else begin
            if (frameWrap) begin
                frameTimer <= '0;
            end else begin
                frameTimer <= frameTimer + 16'd1;
            end
            // A fresh boundary wins over the clear so it is never lost.
            if (frameWrap) begin
                sofDue <= 1'b1;
            end else if (sofStart) begin
                sofDue <= 1'b0;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // FSM next-state logic; SOF beats a pending transaction in IDLE.
    always_comb begin
        // NOTE: default first so no path leaves nextState unassigned (no latch).
        nextState = state;
        unique case (state)
            IDLE: begin
                if (sofDue) begin
                    nextState = SOF_TX;
                end else if (swTransBusy && launchOk) begin
                    nextState = TRANS_ACT;
                end
            end
            SOF_TX: begin
                if (sofTxDone) begin
                    nextState = IDLE;
                end
            end
            TRANS_ACT: begin
                if (transComplete) begin
                    nextState = TRANS_WAIT;
                end
            end
            TRANS_WAIT: begin
                if (waitCnt == WAIT_LAST) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Software request capture, busy flag and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            swTransBusy <= 1'b0;
            swTransDone <= 1'b0;
            latchedType <= '0;
        end else begin
            swTransDone <= (state == TRANS_ACT) && transComplete;
            if ((state == TRANS_ACT) && transComplete) begin
                swTransBusy <= 1'b0;
            end else if (swCapture) begin
                swTransBusy <= 1'b1;
                latchedType <= swTransType;
            end
        end
    end

    // Registered handshake outputs, frame number and post-transaction delay.
    always_ff @(posedge clk) begin
        if (rst) begin
            transReq  <= 1'b0;
            transType <= '0;
            sofTxReq  <= 1'b0;
            sofSent   <= 1'b0;
            frameNum  <= '0;
            waitCnt   <= '0;
        end else begin
            transReq <= (nextState == TRANS_ACT);
            sofTxReq <= (nextState == SOF_TX);
            sofSent  <= (state == SOF_TX) && sofTxDone;
            // transType only changes at launch so it is stable while transReq=1.
            if (transStart) begin
                transType <= latchedType;
            end
            if ((state == SOF_TX) && sofTxDone) begin
                frameNum <= frameNum + 11'd1;
            end
            if (state == TRANS_WAIT) begin
                waitCnt <= waitCnt + 4'd1;
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule
